reg_bank_16x16: RTL
===================

Name: reg_bank_16x16

Overview:
- Sixteen 16-bit general-purpose registers with a single synchronous write port.
- All sixteen register values drive continuously onto flat outputs r0..r15. These feed the 16:1 16-bit register-select mux, which forms the ALU operand path.
- Write address decode is done internally.
- Also tracks per-register "written since clear" (dirty) bits and the most recent write target, for debug and hazard logic.

Parameters:
- DATA_W, 16, width of each register and of wr_data.
- ZERO_R0, 0, when 1 r0 is hard-wired to zero and writes to address 0 are ignored (no dirty or last-write update).
- RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; one write per asserted cycle.
- wr_addr  input  4  destination register index 0..15.
- wr_data  input  DATA_W  write-back value.
- clr_dirty  input  1  clears all dirty bits.
- r0 .. r15  output  DATA_W each  current register contents (sixteen separate ports).
- dirty  output  16  bit i set when register i has been written since the last reset or clr_dirty.
- last_addr  output  4  index of the most recent accepted write.
- last_valid  output  1  high once any write has been accepted since reset.

Behaviour:
- Reset:
  - Evaluated only at the rising clk edge while reset=1.
  - r0..r15 load RESET_VAL (r0=0 when ZERO_R0=1); dirty=16'h0000; last_addr=4'h0; last_valid=0.
  - Reset has priority over wr_en and clr_dirty in the same cycle.
  - Reset asserted mid-sequence discards that cycle's write.
- Write:
  - On an edge with reset=0 and wr_en=1, register[wr_addr] <= wr_data.
  - All other registers hold.
  - Exactly one register changes per write; decode is 4-to-16 one-hot.
- Latency:
  - The new value appears on the r-output one cycle after the write edge.
  - There is no combinational write-through: same-cycle read of the target shows the old value.
- Outputs r0..r15 are direct register outputs with no combinational path from inputs.
- wr_en=0: no state changes; wr_addr and wr_data are don't-care.
- Dirty tracking:
  - On an accepted write, dirty[wr_addr] <= 1.
  - clr_dirty=1 clears all bits.
  - If clr_dirty and an accepted write occur in the same cycle, the result is dirty = one-hot(wr_addr). The clear applies first and the write's bit is then set.
- Last-write tracking:
  - On an accepted write, last_addr <= wr_addr and last_valid <= 1.
  - clr_dirty does not affect last_addr or last_valid.
- Back-to-back writes to the same address: each cycle overwrites; the final value is that of the last write.
- ZERO_R0=1 with wr_en=1 and wr_addr=0:
  - Treated as no write; r0 stays 0.
  - dirty[0] stays 0; last_addr and last_valid are unchanged.
  - clr_dirty in the same cycle still clears.
- X-free requirement: wr_addr covers all 16 indices, so there is no default/unreachable decode state.

Test Plan:
- Reset with RESET_VAL=16'h0000 -> all r0..r15=0, dirty=0, last_valid=0 on the cycle after reset.
- Write sweep:
  - Stimulus: wr_en=1, wr_addr=i, wr_data=16'hA000+i for i=0..15 on consecutive cycles.
  - Response: each ri=16'hA000+i one cycle after its write; no other register disturbed; dirty=16'hFFFF; last_addr=4'hF.
- Same-cycle interactions:
  - Write r5=16'h1234 with clr_dirty=1 after the sweep -> dirty=16'h0020, r5=16'h1234, last_addr=4'h5.
  - Write r3=16'hBEEF with reset=1 in the same cycle -> r3=0, dirty=0, last_valid=0.
- ZERO_R0=1: write addr 0 data 16'hFFFF -> r0 stays 16'h0000, dirty[0]=0, last_valid unchanged.
- Read-before-write and idle:
  - Write r7=16'h0001, then r7=16'h0002 back-to-back -> r7 reads 16'h0001 for one cycle, then 16'h0002.
  - wr_en=0 with wr_addr=7, wr_data=16'hFFFF -> r7 holds 16'h0002.

Source files
------------

// File: rtl/reg_bank_16x16.sv
// reg_bank_16x16: sixteen general-purpose registers with one synchronous
// write port. Every register value is presented on its own output port so
// the downstream 16:1 operand mux can select any of them. Alongside the
// data, the bank keeps per-register dirty bits (written since reset or
// clr_dirty) and the index of the most recent accepted write.
//
// Write acceptance:
//   - A write is accepted when wr_en=1.
//   - The one exception is ZERO_R0=1 with wr_addr=0, which is treated as
//     no write at all: r0 stays zero and the dirty bits and last-write
//     tracking are left untouched.
//
// Timing:
//   - All outputs come straight from flops. A write becomes visible one
//     cycle after its edge, so there is no write-through to the outputs.
//   - Reset is synchronous and has priority over everything else in the
//     same cycle, including a pending write or clr_dirty.

module reg_bank_16x16 #(
  parameter int                DATA_W    = 16,
  parameter bit                ZERO_R0   = 1'b0,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_dirty,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15,
  output logic [15:0]       dirty,
  output logic [3:0]        last_addr,
  output logic              last_valid
);

  localparam int NREG = 16;

  // With a hard-wired zero r0 the reset value for r0 is forced to zero
  // regardless of RESET_VAL.
  localparam logic [DATA_W-1:0] R0_RESET_VAL = ZERO_R0 ? {DATA_W{1'b0}} : RESET_VAL;

  // 4-to-16 one-hot decode. Every index 0..15 maps to exactly one bit, so
  // the decode has no unreachable state.
  function automatic logic [15:0] decode_1hot(input logic [3:0] addr);
    decode_1hot = 16'h0001 << addr;
  endfunction

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [15:0]       dirty_q;
  logic [15:0]       dirty_d;
  logic [3:0]        last_addr_q;
  logic [3:0]        last_addr_d;
  logic              last_valid_q;
  logic              last_valid_d;

  logic              wr_accept_s;
  logic [15:0]       wr_sel_s;

  // Qualify the write strobe and decode it into a one-hot register select.
  always_comb begin
    wr_accept_s = 1'b0;
    if (wr_en) begin
      if (ZERO_R0 && (wr_addr == 4'd0)) begin
        wr_accept_s = 1'b0;
      end else begin
        wr_accept_s = 1'b1;
      end
    end else begin
      wr_accept_s = 1'b0;
    end
    wr_sel_s = wr_accept_s ? decode_1hot(wr_addr) : 16'h0000;
  end

  // Next register contents: only the selected register takes wr_data.
  // When r0 is hard-wired it is never selected, so it simply holds its
  // zero reset value.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel_s[i]) begin
        regs_d[i] = wr_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Next dirty and last-write state.
  // The clear is applied first and the accepted write's bit is then ORed
  // in, so clear+write in the same cycle leaves exactly one-hot(wr_addr).
  // clr_dirty does not affect the last-write tracking.
  always_comb begin
    dirty_d      = (clr_dirty ? 16'h0000 : dirty_q) | wr_sel_s;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    if (wr_accept_s) begin
      last_addr_d  = wr_addr;
      last_valid_d = 1'b1;
    end else begin
      last_addr_d  = last_addr_q;
      last_valid_d = last_valid_q;
    end
  end

  // State update: synchronous reset has priority over any write or clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == 0) ? R0_RESET_VAL : RESET_VAL;
      end
      dirty_q      <= 16'h0000;
      last_addr_q  <= 4'h0;
      last_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dirty_q      <= dirty_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
    end
  end

  // Outputs are straight register taps; there is no path from the inputs.
  assign r0         = regs_q[0];
  assign r1         = regs_q[1];
  assign r2         = regs_q[2];
  assign r3         = regs_q[3];
  assign r4         = regs_q[4];
  assign r5         = regs_q[5];
  assign r6         = regs_q[6];
  assign r7         = regs_q[7];
  assign r8         = regs_q[8];
  assign r9         = regs_q[9];
  assign r10        = regs_q[10];
  assign r11        = regs_q[11];
  assign r12        = regs_q[12];
  assign r13        = regs_q[13];
  assign r14        = regs_q[14];
  assign r15        = regs_q[15];
  assign dirty      = dirty_q;
  assign last_addr  = last_addr_q;
  assign last_valid = last_valid_q;

endmodule
